// File: rtl/rmii_rx_deframer_pkg.sv
// rtl/rmii_rx_deframer_pkg.sv - shared constants and state type for the RMII receive deframer
package rmii_rx_deframer_pkg;

  localparam logic [7:0] ETH_PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE        = 8'hD5;
  localparam logic [1:0] DIBIT_IDLE          = 2'b00;
  localparam logic [1:0] DIBIT_PRE           = 2'b01;
  localparam logic [1:0] DIBIT_FALSE_CARRIER = 2'b10;
  localparam logic [1:0] DIBIT_SFD           = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

endpackage

// File: rtl/rmii_crs_dv_filter.sv
// rtl/rmii_crs_dv_filter.sv - one-cycle dibit delay with CRS_DV acceptance and end-of-carrier detect
module rmii_crs_dv_filter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic [1:0] dibit,
  output logic       dibit_accept,
  output logic       eoc
);

  logic       crs_dv_q;
  logic [1:0] rxd_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crs_dv_q <= 1'b0;
      rxd_q    <= 2'b00;
    end else begin
      crs_dv_q <= crs_dv;
      rxd_q    <= rxd;
    end
  end

  // Looking one dibit ahead lets the 25 MHz CRS_DV toggle at frame end keep data flowing.
  assign dibit        = rxd_q;
  assign dibit_accept = crs_dv_q | crs_dv;
  assign eoc          = ~crs_dv_q & ~crs_dv;

endmodule

// File: rtl/rmii_rx_deframer.sv
// rtl/rmii_rx_deframer.sv - RMII receive deframer: dibit packing, SFD alignment and frame bracketing
module rmii_rx_deframer
  import rmii_rx_deframer_pkg::*;
#(
  parameter int MIN_PRE_DIBITS  = 8,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rmii_crs_dv,
  input  logic [1:0] rmii_rxd,
  output logic       data_valid,
  output logic [7:0] received_byte,
  output logic       byte_valid,
  output logic       rx_error
);

  localparam int         BC_W      = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [7:0] MIN_PRE_L = 8'(MIN_PRE_DIBITS);
  localparam logic [BC_W-1:0] MAX_L = BC_W'(MAX_FRAME_BYTES);

  logic [1:0] dibit;
  logic       dibit_accept;
  logic       eoc;

  rmii_crs_dv_filter u_filter (
    .clk          (clk),
    .resetn       (resetn),
    .crs_dv       (rmii_crs_dv),
    .rxd          (rmii_rxd),
    .dibit        (dibit),
    .dibit_accept (dibit_accept),
    .eoc          (eoc)
  );

  rx_state_t       state, state_n;
  logic [1:0]      phase, phase_n;
  logic [7:0]      pre_cnt, pre_cnt_n;
  logic [BC_W-1:0] byte_cnt, byte_cnt_n;
  logic [7:0]      sh, sh_n, sh_shift;
  logic [7:0]      byte_n;
  logic            bv_n, err_n, dv_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      phase         <= 2'd0;
      pre_cnt       <= 8'd0;
      byte_cnt      <= '0;
      sh            <= 8'h00;
      data_valid    <= 1'b0;
      received_byte <= 8'h00;
      byte_valid    <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      pre_cnt       <= pre_cnt_n;
      byte_cnt      <= byte_cnt_n;
      sh            <= sh_n;
      data_valid    <= dv_n;
      received_byte <= byte_n;
      byte_valid    <= bv_n;
      rx_error      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    pre_cnt_n  = pre_cnt;
    byte_cnt_n = byte_cnt;
    sh_shift   = {dibit, sh[7:2]};
    sh_n       = dibit_accept ? sh_shift : sh;
    byte_n     = received_byte;
    bv_n       = 1'b0;
    err_n      = 1'b0;

    case (state)
      IDLE: begin
        if (dibit_accept) begin
          if (dibit == DIBIT_PRE) begin
            state_n   = PREAMBLE;
            pre_cnt_n = 8'd1;
            phase_n   = 2'd1;
          end else if (dibit != DIBIT_IDLE) begin
            err_n   = 1'b1;
            state_n = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (eoc) begin
          state_n = IDLE;
        end else if (dibit_accept) begin
          if (dibit == DIBIT_PRE) begin
            if (pre_cnt != 8'hFF) pre_cnt_n = pre_cnt + 8'd1;
            phase_n = phase + 2'd1;
            if (phase == 2'd3) begin
              byte_n = ETH_PREAMBLE_BYTE;
              bv_n   = 1'b1;
            end
          end else if (dibit == DIBIT_SFD && sh_shift == ETH_SFD_BYTE && pre_cnt >= MIN_PRE_L) begin
            // SFD realigns byte boundaries regardless of the preamble phase.
            byte_n     = ETH_SFD_BYTE;
            bv_n       = 1'b1;
            phase_n    = 2'd0;
            byte_cnt_n = '0;
            state_n    = DATA;
          end else begin
            err_n   = 1'b1;
            state_n = DROP;
          end
        end
      end

      DATA: begin
        if (eoc) begin
          err_n   = (phase != 2'd0);
          state_n = IDLE;
        end else if (dibit_accept) begin
          phase_n = phase + 2'd1;
          if (phase == 2'd3) begin
            if (byte_cnt == MAX_L) begin
              err_n   = 1'b1;
              state_n = DROP;
            end else begin
              byte_n     = sh_shift;
              bv_n       = 1'b1;
              byte_cnt_n = byte_cnt + 1'b1;
            end
          end
        end
      end

      DROP: begin
        if (eoc) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    dv_n = (state_n == PREAMBLE) || (state_n == DATA);
  end

endmodule
